// File: rtl/gray_pkg.sv
// Shared constants for the Gray/binary up-down counter: output code selectors and default width.
package gray_pkg;

  localparam int DEFAULT_WIDTH = 3;

  localparam logic MODE_BIN  = 1'b0;
  localparam logic MODE_GRAY = 1'b1;

endpackage

// File: rtl/bin_to_gray.sv
// Purely combinational binary-to-reflected-Gray converter.
// Each Gray bit is the XOR of a binary bit and its upper neighbour; the MSB passes through.
module bin_to_gray #(
  parameter int WIDTH = 3
) (
  input  logic [WIDTH-1:0] bin_i,
  output logic [WIDTH-1:0] gray_o
);

  assign gray_o = bin_i ^ (bin_i >> 1);

endmodule

// File: rtl/gray_counter.sv
// Up/down modulo-2^WIDTH counter with synchronous load and a binary or Gray registered output.
// Output and wrap pulse are registered, so both reflect the state one cycle after the edge.
module gray_counter
  import gray_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             select,
  output logic [WIDTH-1:0] out,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] MAX_VAL = '1;

  logic [WIDTH-1:0] bin_q, bin_d;
  logic [WIDTH-1:0] gray_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             wrap_q, wrap_d;

  // Load beats enable; only a real count step across the boundary flags a wrap.
  always_comb begin
    bin_d  = bin_q;
    wrap_d = 1'b0;
    if (load) begin
      bin_d = load_val;
    end else if (en) begin
      if (up) begin
        bin_d  = bin_q + WIDTH'(1);
        wrap_d = (bin_q == MAX_VAL);
      end else begin
        bin_d  = bin_q - WIDTH'(1);
        wrap_d = (bin_q == '0);
      end
    end
  end

  bin_to_gray #(
    .WIDTH(WIDTH)
  ) u_bin_to_gray (
    .bin_i  (bin_d),
    .gray_o (gray_d)
  );

  // Encoding is taken from the next state, so a select change re-encodes even a held value.
  assign out_d = (select == MODE_GRAY) ? gray_d : bin_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_q  <= '0;
      out_q  <= '0;
      wrap_q <= 1'b0;
    end else begin
      bin_q  <= bin_d;
      out_q  <= out_d;
      wrap_q <= wrap_d;
    end
  end

  assign out  = out_q;
  assign wrap = wrap_q;

endmodule
